// File: rtl/apb_uart_regfile.sv
// apb_uart_regfile: APB register block for the UART. It holds the TX and RX FIFOs, the sticky
// overrun flags, the control and baud divisor registers, and the combined interrupt.
// Every APB access takes one wait state. An unmapped address returns PSLVERR.
//
// Ports:
//   PCLK, PRESETn         APB clock and asynchronous active-low reset
//   PSEL/PENABLE/PWRITE   APB control inputs
//   PADDR, PWDATA         byte address and write data
//   PRDATA, PREADY,       registered read data, completion and error outputs
//   PSLVERR
//   tx_data, tx_valid,    TX FIFO head, offered to the transmitter; popped on valid & ready
//   tx_ready
//   rx_data, rx_valid     character from the receiver, pushed on a one-cycle strobe
//   cd                    baud divisor
//   tx_en, rx_en          CTRL[0], CTRL[1]
//   irq                   combined interrupt
module apb_uart_regfile #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CD_W       = 13,
  parameter int unsigned CD_RESET   = 325
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [CD_W-1:0]   cd,
  output logic              tx_en,
  output logic              rx_en,
  output logic              irq
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PtrOne = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] Depth  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            r_state;
  logic [31:0]       r_prdata;
  logic              r_pready;
  logic              r_pslverr;
  logic [PTR_W:0]    r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [5:0]        r_ctrl;
  logic              r_tx_ovr, r_rx_ovr;
  logic [CD_W-1:0]   r_cd;

  logic [PTR_W:0] w_tx_count, w_rx_count;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_commit, w_sel_data, w_sel_status, w_sel_ctrl, w_sel_level, w_sel_baud, w_mapped;
  logic w_tx_wr, w_tx_push, w_tx_pop, w_tx_ovf;
  logic w_rx_rd, w_rx_pop, w_rx_in, w_rx_push, w_rx_ovf;
  logic w_st_wr, w_ctrl_wr, w_baud_wr, w_baud_zero, w_err;
  logic [DATA_W-1:0] w_rx_head;
  logic [31:0] w_rdata;
  logic w_unused_pwdata;

  assign w_unused_pwdata = ^PWDATA;

  // Pointers carry one extra bit so full and empty are told apart by the difference.
  assign w_tx_count = r_tx_wp - r_tx_rp;
  assign w_rx_count = r_rx_wp - r_rx_rp;
  assign w_tx_full  = (w_tx_count == Depth);
  assign w_rx_full  = (w_rx_count == Depth);
  assign w_tx_empty = (w_tx_count == '0);
  assign w_rx_empty = (w_rx_count == '0);

  assign w_sel_data   = (PADDR == 8'h00);
  assign w_sel_status = (PADDR == 8'h04);
  assign w_sel_ctrl   = (PADDR == 8'h08);
  assign w_sel_level  = (PADDR == 8'h0C);
  assign w_sel_baud   = (PADDR == 8'h10);
  assign w_mapped     = w_sel_data | w_sel_status | w_sel_ctrl | w_sel_level | w_sel_baud;

  // All register and FIFO side effects commit on the single WAIT cycle of a transfer.
  assign w_commit  = (r_state == StWait);
  assign w_tx_wr   = w_commit & PWRITE & w_sel_data;
  // A push into a full TX FIFO overflows even if the transmitter pops in the same cycle.
  assign w_tx_push = w_tx_wr & ~w_tx_full;
  assign w_tx_ovf  = w_tx_wr & w_tx_full;
  assign w_tx_pop  = tx_valid & tx_ready;

  assign w_rx_rd   = w_commit & ~PWRITE & w_sel_data;
  assign w_rx_pop  = w_rx_rd & ~w_rx_empty;
  assign w_rx_in   = rx_valid & r_ctrl[1];
  // A concurrent APB pop frees the slot, so a push into a full RX FIFO then succeeds.
  assign w_rx_push = w_rx_in & (~w_rx_full | w_rx_pop);
  assign w_rx_ovf  = w_rx_in & w_rx_full & ~w_rx_pop;

  assign w_st_wr     = w_commit & PWRITE & w_sel_status;
  assign w_ctrl_wr   = w_commit & PWRITE & w_sel_ctrl;
  assign w_baud_wr   = w_commit & PWRITE & w_sel_baud;
  assign w_baud_zero = (PWDATA[CD_W-1:0] == '0);
  assign w_err       = ~w_mapped | (PWRITE & w_sel_data & w_tx_full) |
                       (PWRITE & w_sel_baud & w_baud_zero);

  assign w_rx_head = r_rx_mem[r_rx_rp[PTR_W-1:0]];

  always_comb begin
    w_rdata = '0;
    case (PADDR)
      8'h00:   w_rdata = w_rx_empty ? '0 : {{(32-DATA_W){1'b0}}, w_rx_head};
      8'h04:   w_rdata = {26'b0, w_rx_empty, w_tx_empty, r_rx_ovr, r_tx_ovr, w_rx_full, w_tx_full};
      8'h08:   w_rdata = {26'b0, r_ctrl};
      8'h0C:   w_rdata = {16'b0, 8'(w_rx_count), 8'(w_tx_count)};
      8'h10:   w_rdata = {{(32-CD_W){1'b0}}, r_cd};
      default: w_rdata = '0;
    endcase
  end

  // Access FSM with registered APB outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= StIdle;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          if (PSEL && PENABLE && !r_pready) r_state <= StWait;
        end
        StWait: begin
          r_pready  <= 1'b1;
          r_pslverr <= w_err;
          r_prdata  <= PWRITE ? '0 : w_rdata;
          r_state   <= StDone;
        end
        StDone: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_ctrl   <= '0;
      r_tx_ovr <= 1'b0;
      r_rx_ovr <= 1'b0;
      r_cd     <= CD_W'(CD_RESET);
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PtrOne;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PtrOne;
      if (w_rx_push) r_rx_wp <= r_rx_wp + PtrOne;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PtrOne;
      if (w_ctrl_wr) r_ctrl <= PWDATA[5:0];
      if (w_baud_wr && !w_baud_zero) r_cd <= PWDATA[CD_W-1:0];
      // A new overrun beats a simultaneous write-1-to-clear.
      if (w_tx_ovf)                   r_tx_ovr <= 1'b1;
      else if (w_st_wr && PWDATA[2])  r_tx_ovr <= 1'b0;
      if (w_rx_ovf)                   r_rx_ovr <= 1'b1;
      else if (w_st_wr && PWDATA[3])  r_rx_ovr <= 1'b0;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge PCLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[PTR_W-1:0]] <= PWDATA[DATA_W-1:0];
    if (w_rx_push) r_rx_mem[r_rx_wp[PTR_W-1:0]] <= rx_data;
  end

  assign PRDATA   = r_prdata;
  assign PREADY   = r_pready;
  assign PSLVERR  = r_pslverr;
  assign tx_data  = r_tx_mem[r_tx_rp[PTR_W-1:0]];
  assign tx_en    = r_ctrl[0];
  assign rx_en    = r_ctrl[1];
  assign tx_valid = r_ctrl[0] & ~w_tx_empty;
  assign cd       = r_cd;
  assign irq      = (r_ctrl[3] & ~w_rx_empty) | (r_ctrl[2] & w_tx_empty) |
                    (r_ctrl[4] & r_tx_ovr) | (r_ctrl[5] & r_rx_ovr);

endmodule

// File: tb/tb_apb_uart_regfile.sv
module tb_apb_uart_regfile;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CDW   = 13;
  localparam int unsigned CDR   = 325;

  logic           PCLK = 1'b0;
  logic           PRESETn = 1'b0;
  logic           PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]     PADDR = '0;
  logic [31:0]    PWDATA = '0;
  logic [31:0]    PRDATA;
  logic           PREADY, PSLVERR;
  logic [DW-1:0]  tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic [DW-1:0]  rx_data = '0;
  logic           rx_valid = 1'b0;
  logic [CDW-1:0] cd;
  logic           tx_en, rx_en, irq;

  int checks = 0;
  int failures = 0;

  // Reference model: plain queues and flags following the register map rules.
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  bit          m_txovr, m_rxovr;
  logic [5:0]  m_ctrl;
  logic [12:0] m_cd;

  logic [31:0] rd;
  logic        er;

  apb_uart_regfile #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CD_W(CDW), .CD_RESET(CDR)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .cd(cd), .tx_en(tx_en), .rx_en(rx_en), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_tx.delete();
    m_rx.delete();
    m_txovr = 0;
    m_rxovr = 0;
    m_ctrl  = '0;
    m_cd    = 13'(CDR);
  endtask

  function automatic logic [31:0] m_status();
    return {26'b0, m_rx.size() == 0, m_tx.size() == 0, m_rxovr, m_txovr,
            m_rx.size() == DEPTH, m_tx.size() == DEPTH};
  endfunction

  function automatic logic m_irq();
    return (m_ctrl[3] && m_rx.size() != 0) || (m_ctrl[2] && m_tx.size() == 0) ||
           (m_ctrl[4] && m_txovr) || (m_ctrl[5] && m_rxovr);
  endfunction

  task automatic check_outputs();
    logic exp_valid;
    exp_valid = m_ctrl[0] && (m_tx.size() != 0);
    chk("tx_valid", {31'b0, tx_valid}, {31'b0, exp_valid});
    if (exp_valid) chk("tx_data", {24'b0, tx_data}, {24'b0, m_tx[0]});
    chk("irq", {31'b0, irq}, {31'b0, m_irq()});
    chk("cd", {19'b0, cd}, {19'b0, m_cd});
    chk("tx_en", {31'b0, tx_en}, {31'b0, m_ctrl[0]});
    chk("rx_en", {31'b0, rx_en}, {31'b0, m_ctrl[1]});
  endtask

  // One non-APB cycle with optional receiver strobe and transmitter ready.
  task automatic idle_cycle(input bit rv, input logic [7:0] d, input bit tr);
    rx_valid = rv;
    rx_data  = d;
    tx_ready = tr;
    check_outputs();
    @(posedge PCLK);
    if (tr && m_ctrl[0] && m_tx.size() != 0) void'(m_tx.pop_front());
    if (rv && m_ctrl[1]) begin
      if (m_rx.size() < DEPTH) m_rx.push_back(d);
      else m_rxovr = 1;
    end
    #1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
  endtask

  // Full APB transfer; optionally strobes rx_valid in the DUT's commit (WAIT) cycle.
  task automatic op(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                    input bit strobe, input logic [7:0] sd,
                    output logic [31:0] rd_o, output logic err_o);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [5:0]  ctrl_pre;
    int          cyc;
    exp_rd   = '0;
    exp_err  = 1'b0;
    ctrl_pre = m_ctrl;
    case (addr)
      8'h00: begin
        if (wr) begin
          if (m_tx.size() == DEPTH) begin
            m_txovr = 1;
            exp_err = 1'b1;
          end else m_tx.push_back(wd[7:0]);
        end else if (m_rx.size() != 0) exp_rd = {24'b0, m_rx.pop_front()};
      end
      8'h04: begin
        if (wr) begin
          if (wd[2]) m_txovr = 0;
          if (wd[3]) m_rxovr = 0;
        end else exp_rd = m_status();
      end
      8'h08: if (wr) m_ctrl = wd[5:0]; else exp_rd = {26'b0, m_ctrl};
      8'h0C: exp_rd = {16'b0, 8'(m_rx.size()), 8'(m_tx.size())};
      8'h10: begin
        if (wr) begin
          if (wd[12:0] == '0) exp_err = 1'b1;
          else m_cd = wd[12:0];
        end else exp_rd = {19'b0, m_cd};
      end
      default: exp_err = 1'b1;
    endcase
    if (strobe && ctrl_pre[1]) begin
      if (m_rx.size() < DEPTH) m_rx.push_back(sd);
      else m_rxovr = 1;
    end

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cyc = 0;
    do begin
      @(posedge PCLK); #1;
      cyc++;
      rx_valid = strobe && (cyc == 1);
      rx_data  = sd;
    end while (!PREADY && cyc < 10);
    rx_valid = 1'b0;
    chk("pready_latency", cyc, 2);
    rd_o  = PRDATA;
    err_o = PSLVERR;
    chk($sformatf("pslverr_%s_%02h", wr ? "wr" : "rd", addr), {31'b0, PSLVERR}, {31'b0, exp_err});
    if (!wr) chk($sformatf("prdata_%02h", addr), PRDATA, exp_rd);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    chk("pready_one_cycle", {31'b0, PREADY}, 32'h0);
  endtask

  initial begin
    int          k;
    int          nidle;
    logic [31:0] w;
    bit          s;
    logic [7:0]  sd;
    logic [7:0]  ua;

    m_reset();
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_pready", {31'b0, PREADY}, 32'h0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_cd", {19'b0, cd}, 32'd325);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Reset values of every register.
    op(0, 8'h00, 0, 0, 0, rd, er); chk("rst_data", rd, 32'h0);
    op(0, 8'h04, 0, 0, 0, rd, er); chk("rst_status", rd, 32'h30);
    op(0, 8'h08, 0, 0, 0, rd, er); chk("rst_ctrl", rd, 32'h0);
    op(0, 8'h0C, 0, 0, 0, rd, er); chk("rst_level", rd, 32'h0);
    op(0, 8'h10, 0, 0, 0, rd, er); chk("rst_baud", rd, 32'd325);

    // TX fill to overflow, then drain.
    for (int i = 0; i < 8; i++) op(1, 8'h00, 32'h41 + i, 0, 0, rd, er);
    op(0, 8'h0C, 0, 0, 0, rd, er); chk("tx_level8", {24'b0, rd[7:0]}, 32'd8);
    op(1, 8'h00, 32'h49, 0, 0, rd, er); chk("tx_ovf_err", {31'b0, er}, 32'h1);
    op(0, 8'h04, 0, 0, 0, rd, er); chk("tx_ovf_status", rd & 32'h17, 32'h05);
    op(1, 8'h08, 32'h1, 0, 0, rd, er);
    for (int i = 0; i < 8; i++) begin
      chk("tx_drain", {24'b0, tx_data}, 32'h41 + i);
      idle_cycle(0, 8'h00, 1);
    end
    chk("tx_drained_valid", {31'b0, tx_valid}, 32'h0);
    op(0, 8'h04, 0, 0, 0, rd, er); chk("tx_empty_flag", {31'b0, rd[4]}, 32'h1);
    op(1, 8'h04, 32'h04, 0, 0, rd, er);

    // RX overflow, drain, empty read, overrun clear.
    op(1, 8'h08, 32'h2, 0, 0, rd, er);
    for (int i = 0; i < 9; i++) idle_cycle(1, 8'(8'h10 + i), 0);
    op(0, 8'h04, 0, 0, 0, rd, er); chk("rx_ovr_set", {31'b0, rd[3]}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      op(0, 8'h00, 0, 0, 0, rd, er); chk("rx_read", rd, 32'h10 + i);
    end
    op(0, 8'h00, 0, 0, 0, rd, er);
    chk("rx_empty_read", rd, 32'h0);
    chk("rx_empty_err", {31'b0, er}, 32'h0);
    op(1, 8'h04, 32'h08, 0, 0, rd, er);
    op(0, 8'h04, 0, 0, 0, rd, er); chk("rx_ovr_clr", {31'b0, rd[3]}, 32'h0);

    // RX full with a strobe in the same cycle as the popping read.
    for (int i = 0; i < 8; i++) idle_cycle(1, 8'(8'h20 + i), 0);
    op(0, 8'h00, 0, 1, 8'h28, rd, er); chk("rx_simul_pop", rd, 32'h20);
    op(0, 8'h0C, 0, 0, 0, rd, er); chk("rx_simul_level", {24'b0, rd[15:8]}, 32'd8);
    op(0, 8'h04, 0, 0, 0, rd, er); chk("rx_simul_noovr", {31'b0, rd[3]}, 32'h0);
    for (int i = 0; i < 8; i++) op(0, 8'h00, 0, 0, 0, rd, er);
    chk("rx_simul_last", rd, 32'h28);

    // Baud divisor and unmapped access.
    op(1, 8'h10, 32'd27, 0, 0, rd, er); chk("baud27", {19'b0, cd}, 32'd27);
    op(1, 8'h10, 32'd0, 0, 0, rd, er);
    chk("baud0_err", {31'b0, er}, 32'h1);
    chk("baud0_keep", {19'b0, cd}, 32'd27);
    op(0, 8'h14, 0, 0, 0, rd, er);
    chk("unmapped_err", {31'b0, er}, 32'h1);
    chk("unmapped_data", rd, 32'h0);

    // RX interrupt timing.
    op(1, 8'h08, 32'h0A, 0, 0, rd, er);
    chk("irq_idle", {31'b0, irq}, 32'h0);
    idle_cycle(1, 8'h55, 0);
    chk("irq_rise", {31'b0, irq}, 32'h1);
    op(0, 8'h00, 0, 0, 0, rd, er);
    chk("irq_fall", {31'b0, irq}, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      k  = $urandom_range(0, 9);
      w  = $urandom;
      s  = ($urandom_range(0, 3) == 0);
      sd = 8'($urandom);
      case (k)
        0, 1: op(1, 8'h00, w, s, sd, rd, er);
        2, 3: op(0, 8'h00, 0, s, sd, rd, er);
        4: op(0, 8'h04, 0, s, sd, rd, er);
        5: op(1, 8'h04, w, s, sd, rd, er);
        6: op(1, 8'h08, w, s, sd, rd, er);
        7: op(0, ($urandom_range(0, 1) == 0) ? 8'h08 : 8'h0C, 0, s, sd, rd, er);
        8: op($urandom_range(0, 1) == 0, 8'h10, ($urandom_range(0, 3) == 0) ? 32'h0 : w,
              s, sd, rd, er);
        default: begin
          case ($urandom_range(0, 4))
            0: ua = 8'h14;
            1: ua = 8'h01;
            2: ua = 8'h06;
            3: ua = 8'hFC;
            default: ua = 8'h80;
          endcase
          op($urandom_range(0, 1) == 0, ua, w, s, sd, rd, er);
        end
      endcase
      nidle = $urandom_range(0, 3);
      for (int j = 0; j < nidle; j++)
        idle_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset asserted in the WAIT cycle of a DATA write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h5A;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_pready", {31'b0, PREADY}, 32'h0);
    chk("mid_rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    chk("mid_rst_prdata", PRDATA, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("mid_rst_cd", {19'b0, cd}, 32'd325);
    chk("mid_rst_en", {30'b0, tx_en, rx_en}, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    m_reset();
    @(posedge PCLK); #1;
    op(0, 8'h0C, 0, 0, 0, rd, er); chk("mid_rst_level", rd, 32'h0);
    op(0, 8'h04, 0, 0, 0, rd, er); chk("mid_rst_status", rd, 32'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
